// File: rtl/dir_access_arbiter_if.sv
// Bus bundle between the directory access arbiter, its two requesters
// and the TIDC coherence directory. The arbiter sits on the slave modport.
interface dir_access_arbiter_if;
    // Requester side: request, lookup response, commit
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_addr;
    logic         rsp_valid;
    logic         rsp_id;
    logic [2:0]   rsp_state;
    logic [1:0]   rsp_presence;
    logic [1:0]   rsp_tip;
    logic         cmt_valid;
    logic         cmt_id;
    logic         cmt_write;
    logic [2:0]   cmt_state;
    logic [1:0]   cmt_presence;
    logic [1:0]   cmt_tip;
    logic         cmt_ready;
    // Directory side: lookup and update ports
    logic         dir_lookup_req;
    logic [63:0]  dir_lookup_addr;
    logic [2:0]   dir_lookup_state;
    logic [1:0]   dir_lookup_presence;
    logic [1:0]   dir_lookup_tip_state;
    logic         dir_update_req;
    logic [63:0]  dir_update_addr;
    logic [2:0]   dir_update_state;
    logic [1:0]   dir_update_presence;
    logic [1:0]   dir_update_tip_state;
    logic         dir_update_done;

    modport slave (
        input  req_valid, req_addr,
        input  cmt_valid, cmt_id, cmt_write, cmt_state, cmt_presence, cmt_tip,
        input  dir_lookup_state, dir_lookup_presence, dir_lookup_tip_state,
        input  dir_update_done,
        output req_ready,
        output rsp_valid, rsp_id, rsp_state, rsp_presence, rsp_tip,
        output cmt_ready,
        output dir_lookup_req, dir_lookup_addr,
        output dir_update_req, dir_update_addr, dir_update_state,
        output dir_update_presence, dir_update_tip_state
    );

    modport master (
        output req_valid, req_addr,
        output cmt_valid, cmt_id, cmt_write, cmt_state, cmt_presence, cmt_tip,
        output dir_lookup_state, dir_lookup_presence, dir_lookup_tip_state,
        output dir_update_done,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_state, rsp_presence, rsp_tip,
        input  cmt_ready,
        input  dir_lookup_req, dir_lookup_addr,
        input  dir_update_req, dir_update_addr, dir_update_state,
        input  dir_update_presence, dir_update_tip_state
    );
endinterface

// File: rtl/dir_access_arbiter.sv
// Serializes directory read-modify-write slots between the L1 acquire
// handler (requester 0) and the release/probe handler (requester 1).
// A slot is lookup -> response -> commit/abort -> optional update; only one
// is in flight at a time, and a watchdog aborts a slot whose owner stalls.
module dir_access_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMER_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dir_access_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_RESP, S_WAIT_CMT, S_UPDATE
    } state_t;

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic               WDOG_ON      = (TIMEOUT_CYCLES != 0);

    state_t             r_state;
    logic               r_rr_ptr;
    logic               r_owner;
    logic [TIMER_W-1:0] r_timer;
    logic [63:0]        r_addr;
    logic [2:0]         r_rsp_state;
    logic [1:0]         r_rsp_presence;
    logic [1:0]         r_rsp_tip;
    logic [2:0]         r_upd_state;
    logic [1:0]         r_upd_presence;
    logic [1:0]         r_upd_tip;
    logic               r_lookup_req;
    logic               r_rsp_valid;
    logic               r_update_req;
    logic               r_busy;

    logic               w_winner;
    logic               w_grant;
    logic               w_cmt_accept;
    logic               w_timeout;

    // Pick the winner: a lone requester wins, a tie goes to the round-robin pointer
    always_comb begin
        w_winner = 1'b0;
        unique case (bus.req_valid)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = r_rr_ptr;
            default: w_winner = 1'b0;
        endcase
    end

    assign w_grant      = (r_state == S_IDLE) && (bus.req_valid != 2'b00);
    // Only the slot owner may commit; foreign commits are never acknowledged
    assign w_cmt_accept = (r_state == S_WAIT_CMT) && bus.cmt_valid && (bus.cmt_id == r_owner);
    // A commit landing on the last allowed cycle beats the watchdog
    assign w_timeout    = WDOG_ON && (r_state == S_WAIT_CMT) &&
                          (r_timer == TIMEOUT_LAST) && !w_cmt_accept;

    assign bus.req_ready = w_grant ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.cmt_ready = w_cmt_accept;

    assign bus.dir_lookup_req       = r_lookup_req;
    assign bus.dir_lookup_addr      = r_addr;
    assign bus.rsp_valid            = r_rsp_valid;
    assign bus.rsp_id               = r_owner;
    assign bus.rsp_state            = r_rsp_state;
    assign bus.rsp_presence         = r_rsp_presence;
    assign bus.rsp_tip              = r_rsp_tip;
    assign bus.dir_update_req       = r_update_req;
    assign bus.dir_update_addr      = r_addr;
    assign bus.dir_update_state     = r_upd_state;
    assign bus.dir_update_presence  = r_upd_presence;
    assign bus.dir_update_tip_state = r_upd_tip;
    assign busy                     = r_busy;
    assign timeout_err              = w_timeout;

    // Slot FSM with registered strobes; reset abandons any slot in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= 1'b0;
            r_owner        <= 1'b0;
            r_timer        <= '0;
            r_addr         <= '0;
            r_rsp_state    <= '0;
            r_rsp_presence <= '0;
            r_rsp_tip      <= '0;
            r_upd_state    <= '0;
            r_upd_presence <= '0;
            r_upd_tip      <= '0;
            r_lookup_req   <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_update_req   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_lookup_req <= 1'b0;
            r_rsp_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_addr       <= w_winner ? bus.req_addr[127:64] : bus.req_addr[63:0];
                        r_owner      <= w_winner;
                        r_rr_ptr     <= ~w_winner;
                        r_lookup_req <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_rsp_state    <= bus.dir_lookup_state;
                    r_rsp_presence <= bus.dir_lookup_presence;
                    r_rsp_tip      <= bus.dir_lookup_tip_state;
                    r_rsp_valid    <= 1'b1;
                    r_state        <= S_RESP;
                end
                S_RESP: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_CMT;
                end
                S_WAIT_CMT: begin
                    if (w_cmt_accept) begin
                        if (bus.cmt_write) begin
                            r_upd_state    <= bus.cmt_state;
                            r_upd_presence <= bus.cmt_presence;
                            r_upd_tip      <= bus.cmt_tip;
                            r_update_req   <= 1'b1;
                            r_state        <= S_UPDATE;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (bus.dir_update_done) begin
                        r_update_req <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_update_req <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dir_access_arbiter.sv
// Directed bench for dir_access_arbiter with a small behavioural directory.
module tb_dir_access_arbiter;
    localparam logic [2:0] DIR_STATE_INVALID = 3'd0;
    localparam logic [2:0] DIR_STATE_TRUNK   = 3'd1;
    localparam logic [2:0] DIR_STATE_BRANCH  = 3'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic timeout_err;
    logic done_en = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_writes = 0;

    // Directory entries indexed by addr[15:12]: {state[2:0], presence[1:0], tip[1:0]}
    logic [6:0] dir_mem [16] = '{default: 7'd0};

    dir_access_arbiter_if bus();

    dir_access_arbiter #(.TIMEOUT_CYCLES(4), .TIMER_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign bus.dir_lookup_state     = dir_mem[bus.dir_lookup_addr[15:12]][6:4];
    assign bus.dir_lookup_presence  = dir_mem[bus.dir_lookup_addr[15:12]][3:2];
    assign bus.dir_lookup_tip_state = dir_mem[bus.dir_lookup_addr[15:12]][1:0];
    assign bus.dir_update_done      = bus.dir_update_req & done_en;

    // Directory write port: completes in the cycle it is enabled
    always @(posedge clk) begin
        if (bus.dir_update_req && bus.dir_update_done) begin
            dir_mem[bus.dir_update_addr[15:12]] <= {bus.dir_update_state,
                bus.dir_update_presence, bus.dir_update_tip_state};
            n_writes <= n_writes + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid    = 2'b00;
        bus.req_addr     = '0;
        bus.cmt_valid    = 1'b0;
        bus.cmt_id       = 1'b0;
        bus.cmt_write    = 1'b0;
        bus.cmt_state    = 3'd0;
        bus.cmt_presence = 2'd0;
        bus.cmt_tip      = 2'd0;
    endtask

    task automatic check_idle_outputs();
        chk("idle_busy", busy, 0);
        chk("idle_timeout_err", timeout_err, 0);
        chk("idle_req_ready", bus.req_ready, 0);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        chk("idle_rsp_id", bus.rsp_id, 0);
        chk("idle_rsp_data", {bus.rsp_state, bus.rsp_presence, bus.rsp_tip}, 0);
        chk("idle_cmt_ready", bus.cmt_ready, 0);
        chk("idle_lookup_req", bus.dir_lookup_req, 0);
        chk("idle_lookup_addr", bus.dir_lookup_addr, 0);
        chk("idle_update_req", bus.dir_update_req, 0);
        chk("idle_update_addr", bus.dir_update_addr, 0);
        chk("idle_update_data", {bus.dir_update_state, bus.dir_update_presence,
                                 bus.dir_update_tip_state}, 0);
    endtask

    // Starts at a negedge in IDLE, ends at the negedge of the first WAIT_CMT cycle
    task automatic grant_to_wait(input logic [1:0] rv, input logic [63:0] a0, input logic [63:0] a1,
                                 input logic exp_id, input logic [63:0] exp_addr,
                                 input logic [2:0] es, input logic [1:0] ep, input logic [1:0] et);
        bus.req_valid = rv;
        bus.req_addr  = {a1, a0};
        #1 chk("grant", bus.req_ready, exp_id ? 2'b10 : 2'b01);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("lookup_req", bus.dir_lookup_req, 1);
        chk("lookup_addr", bus.dir_lookup_addr, exp_addr);
        chk("busy_lookup", busy, 1);
        chk("rsp_early", bus.rsp_valid, 0);
        @(negedge clk);
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_id", bus.rsp_id, exp_id);
        chk("rsp_state", bus.rsp_state, es);
        chk("rsp_presence", bus.rsp_presence, ep);
        chk("rsp_tip", bus.rsp_tip, et);
        chk("lookup_req_off", bus.dir_lookup_req, 0);
        @(negedge clk);
        chk("rsp_pulse", bus.rsp_valid, 0);
    endtask

    // Presents a commit for one cycle and advances to the next negedge
    task automatic commit(input logic id, input logic wr, input logic [2:0] s,
                          input logic [1:0] p, input logic [1:0] t, input logic exp_ready);
        bus.cmt_valid    = 1'b1;
        bus.cmt_id       = id;
        bus.cmt_write    = wr;
        bus.cmt_state    = s;
        bus.cmt_presence = p;
        bus.cmt_tip      = t;
        #1 chk("cmt_ready", bus.cmt_ready, exp_ready);
        chk("cmt_no_timeout", timeout_err, 0);
        @(negedge clk);
        bus.cmt_valid = 1'b0;
    endtask

    task automatic txn(input logic [1:0] rv, input logic [63:0] a0, input logic [63:0] a1,
                       input logic exp_id, input logic [63:0] exp_addr,
                       input logic [2:0] es, input logic [1:0] ep, input logic [1:0] et,
                       input logic wr, input logic [2:0] ns, input logic [1:0] np, input logic [1:0] nt);
        grant_to_wait(rv, a0, a1, exp_id, exp_addr, es, ep, et);
        commit(exp_id, wr, ns, np, nt, 1'b1);
        if (wr) begin
            chk("update_req", bus.dir_update_req, 1);
            chk("update_addr", bus.dir_update_addr, exp_addr);
            chk("update_data", {bus.dir_update_state, bus.dir_update_presence,
                                bus.dir_update_tip_state}, {ns, np, nt});
            @(negedge clk);
        end
        chk("txn_done_busy", busy, 0);
        chk("txn_done_update_req", bus.dir_update_req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs();
        rst = 1'b0;

        // Single requester: write a TRUNK entry, then read it back
        txn(2'b01, 64'h1000, 64'h0, 1'b0, 64'h1000, DIR_STATE_INVALID, 2'b00, 2'b00,
            1'b1, DIR_STATE_TRUNK, 2'b01, 2'b01);
        txn(2'b01, 64'h1000, 64'h0, 1'b0, 64'h1000, DIR_STATE_TRUNK, 2'b01, 2'b01,
            1'b0, 3'd0, 2'd0, 2'd0);

        // Round robin from reset: 0, 1, 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        txn(2'b11, 64'h2000, 64'h3000, 1'b0, 64'h2000, 3'd0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 2'd0);
        txn(2'b11, 64'h2000, 64'h3000, 1'b1, 64'h3000, 3'd0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 2'd0);
        txn(2'b11, 64'h2000, 64'h3000, 1'b0, 64'h2000, 3'd0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 2'd0);

        // Foreign commit ignored, then owner releases read-only
        grant_to_wait(2'b10, 64'h2000, 64'h3000, 1'b1, 64'h3000, 3'd0, 2'd0, 2'd0);
        commit(1'b0, 1'b1, DIR_STATE_BRANCH, 2'b11, 2'b11, 1'b0);
        chk("wrong_id_busy", busy, 1);
        chk("wrong_id_no_update", bus.dir_update_req, 0);
        commit(1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 1'b1);
        chk("ro_release_busy", busy, 0);
        chk("ro_release_no_update", bus.dir_update_req, 0);
        chk("ro_release_writes", n_writes, 1);

        // Watchdog: owner 0 stalls while requester 1 waits
        grant_to_wait(2'b01, 64'h2000, 64'h3000, 1'b0, 64'h2000, 3'd0, 2'd0, 2'd0);
        bus.req_valid = 2'b10;
        for (int i = 1; i <= 3; i++) begin
            #1 chk("no_timeout_yet", timeout_err, 0);
            chk("wait_busy", busy, 1);
            chk("wait_no_grant", bus.req_ready, 0);
            @(negedge clk);
        end
        #1 chk("timeout_pulse", timeout_err, 1);
        chk("timeout_busy", busy, 1);
        @(negedge clk);
        chk("timeout_clear", timeout_err, 0);
        chk("timeout_idle", busy, 0);
        chk("timeout_no_update", bus.dir_update_req, 0);

        // Pending requester 1 granted; commits on the exact timeout cycle
        done_en = 1'b0;
        grant_to_wait(2'b10, 64'h2000, 64'h3000, 1'b1, 64'h3000, 3'd0, 2'd0, 2'd0);
        repeat (3) @(negedge clk);
        commit(1'b1, 1'b1, DIR_STATE_BRANCH, 2'b10, 2'b10, 1'b1);
        chk("edge_cmt_no_timeout", timeout_err, 0);
        chk("edge_update_req", bus.dir_update_req, 1);
        chk("edge_update_addr", bus.dir_update_addr, 64'h3000);
        chk("edge_update_data", {bus.dir_update_state, bus.dir_update_presence,
                                 bus.dir_update_tip_state}, {DIR_STATE_BRANCH, 2'b10, 2'b10});
        @(negedge clk);
        chk("update_hold", bus.dir_update_req, 1);
        chk("update_hold_busy", busy, 1);
        done_en = 1'b1;
        @(negedge clk);
        chk("update_done_idle", busy, 0);
        chk("update_done_writes", n_writes, 2);

        // Reset during UPDATE
        done_en = 1'b0;
        grant_to_wait(2'b01, 64'h1000, 64'h3000, 1'b0, 64'h1000, DIR_STATE_TRUNK, 2'b01, 2'b01);
        commit(1'b0, 1'b1, 3'd5, 2'b11, 2'b11, 1'b1);
        chk("pre_rst_update_req", bus.dir_update_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        done_en = 1'b1;
        check_idle_outputs();

        // Reset during WAIT_CMT; lookup confirms the BRANCH write
        grant_to_wait(2'b10, 64'h1000, 64'h3000, 1'b1, 64'h3000, DIR_STATE_BRANCH, 2'b10, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs();

        // Pointer back at 0 and directory untouched by the aborted slot
        txn(2'b11, 64'h1000, 64'h3000, 1'b0, 64'h1000, DIR_STATE_TRUNK, 2'b01, 2'b01,
            1'b0, 3'd0, 2'd0, 2'd0);
        chk("final_writes", n_writes, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
